// File: rtl/deco_frame_feeder.sv
// deco_frame_feeder
// Upstream sequencer for the Deco turbo decoder. Accepts whole coded frames
// over valid/ready and slices each one into BEATS beats of BEAT_W bits, low
// slice first. The beats go out on Deco's start/data protocol. The block then
// waits for done, captures the RES_W-bit decoded result and offers it
// downstream over valid/ready.
//
// Ports
//   clk_p_i        in   clock, rising edge
//   reset_n_i      in   synchronous active-low reset
//   frame_valid_i  in   upstream frame available
//   frame_ready_o  out  a frame can be accepted this cycle
//   frame_data_i   in   coded frame, beat k = frame_data_i[k*BEAT_W +: BEAT_W]
//   deco_start_o   out  Deco start
//   deco_data_o    out  Deco input beat
//   deco_done_i    in   Deco done
//   deco_data_i    in   Deco result, valid with deco_done_i
//   res_valid_o    out  decoded result held
//   res_ready_i    in   downstream consumes result
//   res_data_o     out  decoded result
//   busy_o         out  sequencer not idle
//   timeout_o      out  one-cycle pulse when a frame is aborted for lack of done
//   err_o          out  sticky: done seen outside the wait phase
//   frame_cnt_o    out  results produced since reset, wrapping
module deco_frame_feeder #(
  parameter  int BEAT_W  = 21,
  parameter  int BEATS   = 4,
  parameter  int RES_W   = 5,
  parameter  int TIMEOUT = 1023,
  parameter  int CNT_W   = 16,
  localparam int FRAME_W = BEAT_W * BEATS
) (
  input  logic               clk_p_i,
  input  logic               reset_n_i,
  input  logic               frame_valid_i,
  output logic               frame_ready_o,
  input  logic [FRAME_W-1:0] frame_data_i,
  output logic               deco_start_o,
  output logic [BEAT_W-1:0]  deco_data_o,
  input  logic               deco_done_i,
  input  logic [RES_W-1:0]   deco_data_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [RES_W-1:0]   res_data_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   frame_cnt_o
);

  localparam int IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BEATS - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_WAIT,
    S_GAP
  } state_t;

  state_t              r_state;
  logic [FRAME_W-1:0]  r_frame;  // beats not yet sent, next one in the low slice
  logic [IDX_W-1:0]    r_idx;    // beat currently on deco_data_o
  logic [WCNT_W-1:0]   r_wcnt;   // completed WAIT cycles without done

  // Launch is blocked while a result is pending so it can never be overwritten.
  assign frame_ready_o = (r_state == S_IDLE) && !res_valid_o;

  always_ff @(posedge clk_p_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_frame      <= '0;
      r_idx        <= '0;
      r_wcnt       <= '0;
      deco_start_o <= 1'b0;
      deco_data_o  <= '0;
      res_valid_o  <= 1'b0;
      res_data_o   <= '0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
      err_o        <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      timeout_o <= 1'b0;
      if (res_valid_o && res_ready_i) begin
        res_valid_o <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (deco_done_i) begin
            err_o <= 1'b1;
          end
          if (frame_valid_i && frame_ready_o) begin
            // Beat 0 goes out straight away; the shadow keeps the rest.
            deco_start_o <= 1'b1;
            deco_data_o  <= frame_data_i[BEAT_W-1:0];
            r_frame      <= frame_data_i >> BEAT_W;
            r_idx        <= '0;
            busy_o       <= 1'b1;
            r_state      <= S_BEAT;
          end
        end

        S_BEAT: begin
          if (deco_done_i) begin
            err_o <= 1'b1;
          end
          if (r_idx == LAST_IDX) begin
            // Last beat stays on the bus throughout WAIT.
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end else begin
            deco_data_o <= r_frame[BEAT_W-1:0];
            r_frame     <= r_frame >> BEAT_W;
            r_idx       <= r_idx + 1'b1;
          end
        end

        S_WAIT: begin
          // done takes priority over a timeout expiring in the same cycle.
          if (deco_done_i) begin
            res_data_o   <= deco_data_i;
            res_valid_o  <= 1'b1;
            frame_cnt_o  <= frame_cnt_o + 1'b1;
            deco_start_o <= 1'b0;
            deco_data_o  <= '0;
            r_state      <= S_GAP;
          end else if (r_wcnt == WAIT_LAST) begin
            deco_start_o <= 1'b0;
            timeout_o    <= 1'b1;
            r_state      <= S_GAP;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end

        S_GAP: begin
          // One guaranteed cycle of start low between frames.
          if (deco_done_i) begin
            err_o <= 1'b1;
          end
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deco_frame_feeder.sv
// Testbench for deco_frame_feeder: directed scenarios plus randomized frames
// checked against a cycle-level reference of the frame/beat/wait/gap timing.
module tb_deco_frame_feeder;

  localparam int BEAT_W  = 21;
  localparam int BEATS   = 4;
  localparam int RES_W   = 5;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;
  localparam int FRAME_W = BEAT_W * BEATS;

  logic               clk_p_i = 1'b0;
  logic               reset_n_i;
  logic               frame_valid_i;
  logic               frame_ready_o;
  logic [FRAME_W-1:0] frame_data_i;
  logic               deco_start_o;
  logic [BEAT_W-1:0]  deco_data_o;
  logic               deco_done_i;
  logic [RES_W-1:0]   deco_data_i;
  logic               res_valid_o;
  logic               res_ready_i;
  logic [RES_W-1:0]   res_data_o;
  logic               busy_o;
  logic               timeout_o;
  logic               err_o;
  logic [CNT_W-1:0]   frame_cnt_o;

  deco_frame_feeder #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .RES_W  (RES_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_p_i      (clk_p_i),
    .reset_n_i    (reset_n_i),
    .frame_valid_i(frame_valid_i),
    .frame_ready_o(frame_ready_o),
    .frame_data_i (frame_data_i),
    .deco_start_o (deco_start_o),
    .deco_data_o  (deco_data_o),
    .deco_done_i  (deco_done_i),
    .deco_data_i  (deco_data_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .err_o        (err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[FRAME_W-1:0];
  endfunction

  // Entered at the negedge of cycle T+1 (first cycle after accept).
  // d = WAIT cycle in which done is raised; d > TIMEOUT means never.
  // err_beat = beat index during which a stray done is pulsed (-1 none).
  task automatic frame_body(input logic [FRAME_W-1:0] f, input int d,
                            input logic [RES_W-1:0] r, input int err_beat);
    logic [BEAT_W-1:0] beat;
    bit timed_out;
    int nwait;
    timed_out = (d > TIMEOUT);
    nwait = timed_out ? TIMEOUT : d;
    for (int k = 0; k < BEATS; k++) begin
      beat = f[k*BEAT_W +: BEAT_W];
      chk("beat_start", deco_start_o, 1);
      chk("beat_data", deco_data_o, beat);
      chk("beat_busy", busy_o, 1);
      chk("beat_err", err_o, exp_err);
      if (k == err_beat) begin
        deco_done_i = 1'b1;
        deco_data_i = RES_W'($urandom);
      end
      @(negedge clk_p_i);
      deco_done_i = 1'b0;
      if (k == err_beat) exp_err = 1'b1;
    end
    beat = f[(BEATS-1)*BEAT_W +: BEAT_W];
    for (int w = 1; w <= nwait; w++) begin
      chk("wait_start", deco_start_o, 1);
      chk("wait_data", deco_data_o, beat);
      chk("wait_res_valid", res_valid_o, 0);
      if (w == d) begin
        deco_done_i = 1'b1;
        deco_data_i = r;
      end
      @(negedge clk_p_i);
      deco_done_i = 1'b0;
    end
    // Gap cycle
    if (!timed_out) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk("gap_start", deco_start_o, 0);
    chk("gap_busy", busy_o, 1);
    chk("gap_timeout", timeout_o, timed_out);
    chk("gap_res_valid", res_valid_o, !timed_out);
    if (!timed_out) chk("gap_res_data", res_data_o, r);
    chk("gap_cnt", frame_cnt_o, exp_cnt);
    chk("gap_err", err_o, exp_err);
    @(negedge clk_p_i);
    // Back in IDLE
    chk("idle_busy", busy_o, 0);
    chk("idle_timeout", timeout_o, 0);
    chk("idle_res_valid", res_valid_o, !timed_out && !res_ready_i);
  endtask

  // Entered at a negedge in IDLE with no result pending.
  task automatic run_frame(input logic [FRAME_W-1:0] f, input int d,
                           input logic [RES_W-1:0] r, input int err_beat);
    frame_valid_i = 1'b1;
    frame_data_i  = f;
    chk("accept_ready", frame_ready_o, 1);
    @(negedge clk_p_i);
    frame_valid_i = 1'b0;
    frame_data_i  = rand_frame();
    frame_body(f, d, r, err_beat);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    @(negedge clk_p_i);
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;
  endtask

  initial begin
    logic [FRAME_W-1:0] f;
    logic [RES_W-1:0]   r;
    reset_n_i     = 1'b0;
    frame_valid_i = 1'b0;
    frame_data_i  = '0;
    deco_done_i   = 1'b0;
    deco_data_i   = '0;
    res_ready_i   = 1'b1;
    @(negedge clk_p_i);
    @(negedge clk_p_i);
    chk("rst_start", deco_start_o, 0);
    chk("rst_data", deco_data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_data", res_data_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_cnt", frame_cnt_o, 0);
    chk("rst_ready", frame_ready_o, 1);
    reset_n_i = 1'b1;
    @(negedge clk_p_i);

    // 1: fixed beats, done on third WAIT cycle
    f = {21'h1F0F0, 21'h00F0F, 21'h15555, 21'h0AAAA};
    run_frame(f, 3, 5'b10110, -1);
    chk("t1_cnt", frame_cnt_o, 1);

    // 2: result back-pressure blocks the next launch
    res_ready_i = 1'b0;
    r = RES_W'($urandom);
    run_frame(rand_frame(), 2, r, -1);
    f = rand_frame();
    frame_valid_i = 1'b1;
    frame_data_i  = f;
    for (int i = 0; i < 10; i++) begin
      chk("t2_ready_blocked", frame_ready_o, 0);
      chk("t2_res_held", res_valid_o, 1);
      chk("t2_res_data", res_data_o, r);
      chk("t2_idle_start", deco_start_o, 0);
      @(negedge clk_p_i);
    end
    res_ready_i = 1'b1;
    chk("t2_release_ready", frame_ready_o, 0);
    @(negedge clk_p_i);
    chk("t2_ready", frame_ready_o, 1);
    chk("t2_res_cleared", res_valid_o, 0);
    @(negedge clk_p_i);
    frame_valid_i = 1'b0;
    frame_body(f, 4, RES_W'($urandom), -1);

    // 3: timeout with no done, and done on the last allowed cycle
    run_frame(rand_frame(), TIMEOUT + 5, '0, -1);
    run_frame(rand_frame(), TIMEOUT, RES_W'($urandom), -1);

    // 4: reset during beat 2 drops the frame
    frame_valid_i = 1'b1;
    frame_data_i  = rand_frame();
    @(negedge clk_p_i);
    frame_valid_i = 1'b0;
    @(negedge clk_p_i);
    @(negedge clk_p_i);
    chk("t4_in_beat2", deco_start_o, 1);
    reset_n_i = 1'b0;
    @(negedge clk_p_i);
    reset_n_i = 1'b1;
    exp_cnt = 0;
    exp_err = 1'b0;
    chk("t4_start", deco_start_o, 0);
    chk("t4_data", deco_data_o, 0);
    chk("t4_busy", busy_o, 0);
    chk("t4_cnt", frame_cnt_o, 0);
    chk("t4_res_valid", res_valid_o, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_p_i);
      chk("t4_no_result", res_valid_o, 0);
      chk("t4_idle", busy_o, 0);
    end

    // 5: stray done during beat 1 sets sticky err, frame still completes
    run_frame(rand_frame(), 5, RES_W'($urandom), 1);
    chk("t5_err_sticky", err_o, 1);
    run_frame(rand_frame(), 1, RES_W'($urandom), -1);
    chk("t5_err_still", err_o, 1);

    // Mixed random frames, including timeouts
    for (int i = 0; i < 20; i++) begin
      run_frame(rand_frame(), int'($urandom_range(1, TIMEOUT + 3)), RES_W'($urandom), -1);
    end

    // 6: 160 back-to-back frames after a fresh reset
    do_reset();
    for (int i = 0; i < 160; i++) begin
      run_frame(rand_frame(), int'($urandom_range(1, TIMEOUT)), RES_W'($urandom), -1);
    end
    chk("t6_cnt", frame_cnt_o, 160);
    chk("t6_err", err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
